audio_frame_sequencer: RTL

//  Sequences stereo audio frames between the AudioCodec streaming ports and an FX processing core.
//  - Captures one left and one right ADC sample.
//  - Hands the pair to the FX core with a start/done handshake.
//  - Pushes the processed pair to the DAC ports, then repeats.

---
 rtl/audio_seq_pkg.sv | 20 ++
 rtl/audio_frame_sequencer_if.sv | 58 +++++
 rtl/audio_seq_timer.sv | 31 +++
 rtl/audio_frame_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/audio_seq_pkg.sv
// Shared types for the audio frame sequencer: FSM state encoding and stereo sample pair.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package audio_seq_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_START,
    S_WAIT,
    S_PLAY
  } seq_state_t;

  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_frame_sequencer_if.sv
// Bundles the codec ADC/DAC streams and the FX core handshake seen by the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the codec streams; start/done toward the FX core.
// Ports: master = sequencer side, slave = codec + FX core side.
interface audio_frame_sequencer_if
  import audio_seq_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
);

  logic [DATA_W-1:0] from_adc_left_channel_data;
  logic              from_adc_left_channel_valid;
  logic              from_adc_left_channel_ready;
  logic [DATA_W-1:0] from_adc_right_channel_data;
  logic              from_adc_right_channel_valid;
  logic              from_adc_right_channel_ready;

  logic [DATA_W-1:0] to_dac_left_channel_data;
  logic              to_dac_left_channel_valid;
  logic              to_dac_left_channel_ready;
  logic [DATA_W-1:0] to_dac_right_channel_data;
  logic              to_dac_right_channel_valid;
  logic              to_dac_right_channel_ready;

  logic              fx_start;
  logic [DATA_W-1:0] fx_left_in;
  logic [DATA_W-1:0] fx_right_in;
  logic              fx_done;
  logic [DATA_W-1:0] fx_left_out;
  logic [DATA_W-1:0] fx_right_out;

  modport master (
    input  from_adc_left_channel_data, from_adc_left_channel_valid,
    output from_adc_left_channel_ready,
    input  from_adc_right_channel_data, from_adc_right_channel_valid,
    output from_adc_right_channel_ready,
    output to_dac_left_channel_data, to_dac_left_channel_valid,
    input  to_dac_left_channel_ready,
    output to_dac_right_channel_data, to_dac_right_channel_valid,
    input  to_dac_right_channel_ready,
    output fx_start, fx_left_in, fx_right_in,
    input  fx_done, fx_left_out, fx_right_out
  );

  modport slave (
    output from_adc_left_channel_data, from_adc_left_channel_valid,
    input  from_adc_left_channel_ready,
    output from_adc_right_channel_data, from_adc_right_channel_valid,
    input  from_adc_right_channel_ready,
    input  to_dac_left_channel_data, to_dac_left_channel_valid,
    output to_dac_left_channel_ready,
    input  to_dac_right_channel_data, to_dac_right_channel_valid,
    output to_dac_right_channel_ready,
    input  fx_start, fx_left_in, fx_right_in,
    output fx_done, fx_left_out, fx_right_out
  );

endinterface

// File: rtl/audio_seq_timer.sv
// FX watchdog: saturating cycle counter with clear/enable, flags when LIMIT is reached.
// Latency: expired rises LIMIT enabled cycles after the clear.
// Backpressure: none; holds at LIMIT until cleared.
// Ports: clk, reset (async active-low), clr (sync clear, wins over en), en (count), expired.
module audio_seq_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(LIMIT));

endmodule

// File: rtl/audio_frame_sequencer.sv
// Captures a stereo ADC pair, runs it through the FX core (start/done), plays the result to the DAC.
// Latency: 2nd capture -> fx_start 1 cycle; fx_done -> DAC valid 1 cycle; last DAC xfer -> ADC ready 1 cycle.
// Backpressure: ADC readies low outside S_CAPTURE; DAC valid/data held until each channel's ready.
// Ports: clk, reset (async active-low), enable, bus (codec + FX, master modport), frame_count, fx_timeout.
// Build option: AUDIO_SEQ_TIMEOUT_EN adds the FX_TIMEOUT watchdog with dry passthrough on expiry.
module audio_frame_sequencer
  import audio_seq_pkg::*;
#(
  parameter int          DATA_W     = AUDIO_DATA_W,
  parameter int unsigned FX_TIMEOUT = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  audio_frame_sequencer_if.master bus,
  output logic [CNT_W-1:0]        frame_count,
  output logic                    fx_timeout
);

  seq_state_t       state, state_n;
  logic             cap_l, cap_l_n, cap_r, cap_r_n;
  stereo_t          dry, dry_n;
  stereo_t          dac, dac_n;
  logic             dac_l_vld, dac_l_vld_n, dac_r_vld, dac_r_vld_n;
  logic             adc_l_rdy, adc_l_rdy_n, adc_r_rdy, adc_r_rdy_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic             adc_l_xfer, adc_r_xfer;

  // Sample width is carried by stereo_t; DATA_W only sizes the interface.
  logic [31:0] unused_data_w;
  assign unused_data_w = 32'(DATA_W);

`ifdef AUDIO_SEQ_TIMEOUT_EN
  logic timer_expired;
  logic fx_timeout_q, fx_timeout_n;

  audio_seq_timer #(.LIMIT(FX_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == S_START),
    .en      (state == S_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fx_timeout_q <= 1'b0;
    else        fx_timeout_q <= fx_timeout_n;
  end

  assign fx_timeout = fx_timeout_q;
`else
  logic [31:0] unused_fx_timeout;
  assign unused_fx_timeout = 32'(FX_TIMEOUT);
  assign fx_timeout        = 1'b0;
`endif

  assign adc_l_xfer = adc_l_rdy & bus.from_adc_left_channel_valid;
  assign adc_r_xfer = adc_r_rdy & bus.from_adc_right_channel_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CAPTURE;
      cap_l     <= 1'b0;
      cap_r     <= 1'b0;
      dry       <= '0;
      dac       <= '0;
      dac_l_vld <= 1'b0;
      dac_r_vld <= 1'b0;
      adc_l_rdy <= 1'b0;
      adc_r_rdy <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      cap_l     <= cap_l_n;
      cap_r     <= cap_r_n;
      dry       <= dry_n;
      dac       <= dac_n;
      dac_l_vld <= dac_l_vld_n;
      dac_r_vld <= dac_r_vld_n;
      adc_l_rdy <= adc_l_rdy_n;
      adc_r_rdy <= adc_r_rdy_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cap_l_n     = cap_l;
    cap_r_n     = cap_r;
    dry_n       = dry;
    dac_n       = dac;
    // Each DAC valid drops independently once its own channel transfers.
    dac_l_vld_n = dac_l_vld & ~bus.to_dac_left_channel_ready;
    dac_r_vld_n = dac_r_vld & ~bus.to_dac_right_channel_ready;
    frame_cnt_n = frame_cnt;
`ifdef AUDIO_SEQ_TIMEOUT_EN
    fx_timeout_n = fx_timeout_q;
`endif

    unique case (state)
      S_CAPTURE: begin
        if (enable) begin
          if (adc_l_xfer) begin
            cap_l_n    = 1'b1;
            dry_n.left = bus.from_adc_left_channel_data;
          end
          if (adc_r_xfer) begin
            cap_r_n     = 1'b1;
            dry_n.right = bus.from_adc_right_channel_data;
          end
          if (cap_l_n && cap_r_n) state_n = S_START;
        end else begin
          // Disabled: keep draining the codec, drop any half-captured frame.
          cap_l_n = 1'b0;
          cap_r_n = 1'b0;
        end
      end
      S_START: begin
        cap_l_n = 1'b0;
        cap_r_n = 1'b0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // fx_done has priority over a same-cycle watchdog expiry.
        if (bus.fx_done) begin
          dac_n.left  = bus.fx_left_out;
          dac_n.right = bus.fx_right_out;
          dac_l_vld_n = 1'b1;
          dac_r_vld_n = 1'b1;
          state_n     = S_PLAY;
        end
`ifdef AUDIO_SEQ_TIMEOUT_EN
        else if (timer_expired) begin
          dac_n        = dry;
          dac_l_vld_n  = 1'b1;
          dac_r_vld_n  = 1'b1;
          fx_timeout_n = 1'b1;
          state_n      = S_PLAY;
        end
`endif
      end
      S_PLAY: begin
        if (!dac_l_vld_n && !dac_r_vld_n) begin
          frame_cnt_n = frame_cnt + CNT_W'(1);
          state_n     = S_CAPTURE;
        end
      end
      default: state_n = S_CAPTURE;
    endcase

    // Readies are registered so they are cleanly 0 during reset.
    adc_l_rdy_n = (state_n == S_CAPTURE) && !cap_l_n;
    adc_r_rdy_n = (state_n == S_CAPTURE) && !cap_r_n;
  end

  assign bus.from_adc_left_channel_ready  = adc_l_rdy;
  assign bus.from_adc_right_channel_ready = adc_r_rdy;
  assign bus.to_dac_left_channel_data     = dac.left;
  assign bus.to_dac_left_channel_valid    = dac_l_vld;
  assign bus.to_dac_right_channel_data    = dac.right;
  assign bus.to_dac_right_channel_valid   = dac_r_vld;
  assign bus.fx_start                     = (state == S_START);
  assign bus.fx_left_in                   = dry.left;
  assign bus.fx_right_in                  = dry.right;
  assign frame_count                      = frame_cnt;

endmodule
